// File: rtl/psum_accum_pkg.sv
// Shared widths, int8 saturation bounds and the requantization helper used by
// the partial-sum accumulator and any other int8 output path.
package psum_accum_pkg;

    localparam int PSUM_W  = 20;
    localparam int ACC_W   = 32;
    localparam int BIAS_W  = 16;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 5;
    localparam int TILE_W  = 12;

    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    // Optional ReLU, round-half-up arithmetic right shift, saturate to int8.
    // Work one bit wider than the accumulator so the rounding add never wraps.
    function automatic logic signed [OUT_W-1:0] requant(
        input logic signed [ACC_W-1:0]   acc,
        input logic                      relu,
        input logic        [SHIFT_W-1:0] shift
    );
        logic signed [ACC_W:0]   r;
        logic signed [ACC_W:0]   rnd;
        logic signed [ACC_W:0]   q;
        logic signed [OUT_W-1:0] res;
        r   = (relu && acc[ACC_W-1]) ? '0 : {acc[ACC_W-1], acc};
        rnd = (shift == '0) ? '0 : ((ACC_W+1)'(1) << (shift - 1'b1));
        q   = (r + rnd) >>> shift;
        if (q > (ACC_W+1)'(SAT_MAX))
            res = OUT_W'(SAT_MAX);
        else if (q < (ACC_W+1)'(SAT_MIN))
            res = OUT_W'(SAT_MIN);
        else
            res = q[OUT_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/psum_accum_out_fifo.sv
// First-word fall-through synchronous FIFO. Simultaneous push and pop is
// accepted at any fill level; a push into a full FIFO without a pop is
// dropped and reported on drop.
module psum_out_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             drop
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    // Head word falls through; drive zero while empty so stale storage never shows.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; count alone decides which entries are valid.
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/psum_accum.sv
// Accumulates a configurable number of partial sums per output pixel, adds
// bias, requantizes to int8 and buffers results toward the output writer.
module psum_accum #(
    parameter int PSUM_W = psum_accum_pkg::PSUM_W,
    parameter int ACC_W  = psum_accum_pkg::ACC_W,
    parameter int BIAS_W = psum_accum_pkg::BIAS_W,
    parameter int OUT_W  = psum_accum_pkg::OUT_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     vld_i,
    input  logic signed [PSUM_W-1:0] psum_i,
    input  logic        [11:0]       cfg_num_tiles,
    input  logic        [4:0]        cfg_shift,
    input  logic                     cfg_relu,
    input  logic signed [BIAS_W-1:0] bias_i,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     almost_full_o,
    output logic                     ovf_o,
    output logic                     busy_o
);

    import psum_accum_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic        [TILE_W-1:0]  tile_cnt;
    logic        [TILE_W-1:0]  num_lat;
    logic        [SHIFT_W-1:0] shift_lat;
    logic                      relu_lat;
    logic signed [ACC_W-1:0]   acc;
    logic                      acc_done;
    logic                      pp_vld;
    logic signed [OUT_W-1:0]   pp_data;

    logic        [TILE_W-1:0]  n_cur;
    logic                      last_tile;
    logic signed [ACC_W-1:0]   psum_ext;
    logic signed [ACC_W-1:0]   bias_ext;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic        [CNT_W-1:0]   fifo_count;
    logic                      fifo_drop;
    logic        [OUT_W-1:0]   fifo_dout;

    assign psum_ext = ACC_W'(psum_i);
    assign bias_ext = ACC_W'(bias_i);

    // Group length in force this cycle: live config on the first psum, latched afterwards.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        n_cur = num_lat;
        if (tile_cnt == '0)
            n_cur = (cfg_num_tiles == '0) ? TILE_W'(1) : cfg_num_tiles;
        last_tile = (tile_cnt == n_cur - TILE_W'(1));
    end

    // Tile counter, config latch and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_cnt  <= '0;
            num_lat   <= TILE_W'(1);
            shift_lat <= '0;
            relu_lat  <= 1'b0;
            acc       <= '0;
            acc_done  <= 1'b0;
        end else if (clr_i) begin
            tile_cnt  <= '0;
            num_lat   <= TILE_W'(1);
            shift_lat <= '0;
            relu_lat  <= 1'b0;
            acc       <= '0;
            acc_done  <= 1'b0;
        end else begin
            acc_done <= 1'b0;
            if (vld_i) begin
                if (tile_cnt == '0) begin
                    num_lat   <= n_cur;
                    shift_lat <= cfg_shift;
                    relu_lat  <= cfg_relu;
                    acc       <= bias_ext + psum_ext;
                end else begin
                    acc <= acc + psum_ext;
                end
                if (last_tile) begin
                    tile_cnt <= '0;
                    acc_done <= 1'b1;
                end else begin
                    tile_cnt <= tile_cnt + 1'b1;
                end
            end
        end
    end

    // Post-process stage: requantize a finished accumulation into an int8 result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_vld  <= 1'b0;
            pp_data <= '0;
        end else if (clr_i) begin
            pp_vld  <= 1'b0;
            pp_data <= '0;
        end else begin
            pp_vld <= acc_done;
            if (acc_done)
                pp_data <= requant(acc, relu_lat, shift_lat);
        end
    end

    // Sticky drop flag, cleared only by reset or clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_o <= 1'b0;
        else if (clr_i)
            ovf_o <= 1'b0;
        else if (fifo_drop)
            ovf_o <= 1'b1;
    end

    psum_out_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_i),
        .push  (pp_vld),
        .din   (pp_data),
        .pop   (out_rdy),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .drop  (fifo_drop)
    );

    assign out_data      = fifo_dout;
    assign out_vld       = !fifo_empty;
    assign almost_full_o = (fifo_count >= CNT_W'(DEPTH - 1));
    assign busy_o        = (tile_cnt != '0) || acc_done || pp_vld || !fifo_empty;

endmodule
